// File: rtl/gpu_host_pkg.sv
// Shared encodings for the HPS-to-GPU host bridge: opcodes, read spaces,
// controller states and the captured command layout.
package gpu_host_pkg;

    typedef enum logic [3:0] {
        OP_NOP        = 4'd0,
        OP_SET_ADDR   = 4'd1,
        OP_SET_CORE   = 4'd2,
        OP_WDATA_LO   = 4'd3,
        OP_WDATA_HI   = 4'd4,
        OP_WRITE_INST = 4'd5,
        OP_WRITE_DATA = 4'd6,
        OP_READ       = 4'd7,
        OP_RDATA_HI   = 4'd8,
        OP_CTRL       = 4'd9,
        OP_STATUS     = 4'd10,
        OP_EXC_LO     = 4'd11,
        OP_EXC_HI     = 4'd12
    } opcode_e;

    typedef enum logic [2:0] {
        SP_INST     = 3'd0,
        SP_DATA     = 3'd1,
        SP_REG      = 3'd2,
        SP_FLOATREG = 3'd3,
        SP_SPECIAL  = 3'd4
    } space_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_ACK    = 3'd4
    } state_e;

    // Only the command bits the bridge acts on are retained after capture.
    typedef struct packed {
        logic        toggle;
        logic [3:0]  opcode;
        logic [15:0] payload;
    } cmd_t;

endpackage

// File: rtl/gpu_host_sync.sv
// Two-flop synchroniser for the HPS command word plus a one-cycle stability
// check (word identical on two consecutive synchronised samples).
module gpu_host_sync (
    input  logic        clock,
    input  logic [31:0] h2f_value,
    output logic        sync_toggle,
    output logic [3:0]  sync_opcode,
    output logic [15:0] sync_payload,
    output logic        stable
);
    logic [31:0] meta_q;
    logic [31:0] sync_q;
    logic [31:0] prev_q;

    // Not reset: the chain keeps sampling during reset so the bridge can load
    // the live toggle in the first cycle after release.
    always_ff @(posedge clock) begin
        meta_q <= h2f_value;
        sync_q <= meta_q;
        prev_q <= sync_q;
    end

    always_comb begin
        sync_toggle  = sync_q[31];
        sync_opcode  = sync_q[30:27];
        sync_payload = sync_q[15:0];
        stable       = (sync_q == prev_q);
    end

endmodule

// File: rtl/gpu_host_bridge.sv
// Toggle-handshake command bridge between the HPS and a set of GPU cores:
// decodes command words, drives shared RAM/register access and core control.
module gpu_host_bridge
    import gpu_host_pkg::*;
#(
    parameter int unsigned WORD_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned CORE_COUNT    = 4,
    parameter int unsigned READ_LATENCY  = 2
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [31:0]                      h2f_value,
    output logic [31:0]                      f2h_value,
    output logic [CORE_COUNT-1:0]            core_reset_n,
    output logic [CORE_COUNT-1:0]            core_run,
    input  logic [CORE_COUNT-1:0]            core_halted,
    input  logic [CORE_COUNT-1:0]            core_exception,
    input  logic [CORE_COUNT*24-1:0]         core_exception_data,
    output logic [CORE_COUNT-1:0]            core_select,
    output logic                             enable_write_inst_ram,
    output logic                             enable_write_data_ram,
    output logic [2:0]                       read_space,
    output logic                             enable_read,
    output logic [ADDRESS_WIDTH-1:0]         rw_address,
    output logic [WORD_WIDTH-1:0]            write_data,
    input  logic [CORE_COUNT*WORD_WIDTH-1:0] read_data
);
    logic        s_toggle;
    logic [3:0]  s_opcode;
    logic [15:0] s_payload;
    logic        s_stable;

    gpu_host_sync u_sync (
        .clock        (clock),
        .h2f_value    (h2f_value),
        .sync_toggle  (s_toggle),
        .sync_opcode  (s_opcode),
        .sync_payload (s_payload),
        .stable       (s_stable)
    );

    state_e                   state_q, state_d;
    logic                     init_q, init_d;
    logic                     last_toggle_q, last_toggle_d;
    cmd_t                     cmd_q, cmd_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [WORD_WIDTH-1:0]    wdata_q, wdata_d;
    logic [2:0]               core_idx_q, core_idx_d;
    logic                     bcast_q, bcast_d;
    logic [2:0]               read_space_q, read_space_d;
    logic [2:0]               wait_q, wait_d;
    logic                     err_q, err_d;
    logic [15:0]              resp_q, resp_d;
    logic [15:0]              rdata_hi_q, rdata_hi_d;
    logic [31:0]              f2h_q, f2h_d;
    logic [CORE_COUNT-1:0]    run_q, run_d;
    logic [CORE_COUNT-1:0]    rst_n_q, rst_n_d;

    int unsigned              sel_idx;
    logic [WORD_WIDTH-1:0]    sel_word;
    logic [23:0]              exc_word;
    logic [7:0]               halted8;
    logic [7:0]               exc8;
    logic                     in_exec;
    logic                     read_ok;

    always_comb begin
        sel_idx  = 32'(core_idx_q);
        sel_word = read_data[sel_idx*WORD_WIDTH +: WORD_WIDTH];
        exc_word = core_exception_data[sel_idx*24 +: 24];
        halted8  = '0;
        exc8     = '0;
        for (int unsigned i = 0; i < CORE_COUNT; i++) begin
            halted8[i] = core_halted[i];
            exc8[i]    = core_exception[i];
        end
    end

    always_comb begin
        in_exec               = (state_q == ST_EXEC);
        read_ok               = (cmd_q.payload[2:0] <= 3'(SP_SPECIAL));
        enable_write_inst_ram = in_exec && (cmd_q.opcode == OP_WRITE_INST);
        enable_write_data_ram = in_exec && (cmd_q.opcode == OP_WRITE_DATA);
        enable_read           = in_exec && (cmd_q.opcode == OP_READ) && read_ok;
        read_space            = enable_read ? cmd_q.payload[2:0] : read_space_q;
        core_select           = '0;
        for (int unsigned i = 0; i < CORE_COUNT; i++) begin
            core_select[i] = (sel_idx == i);
        end
        // Broadcast widens the select only while a write pulse is active.
        if ((enable_write_inst_ram || enable_write_data_ram) && bcast_q) begin
            core_select = '1;
        end
    end

    always_comb begin
        state_d       = state_q;
        init_d        = init_q;
        last_toggle_d = last_toggle_q;
        cmd_d         = cmd_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        core_idx_d    = core_idx_q;
        bcast_d       = bcast_q;
        read_space_d  = read_space_q;
        wait_d        = wait_q;
        err_d         = err_q;
        resp_d        = resp_q;
        rdata_hi_d    = rdata_hi_q;
        f2h_d         = f2h_q;
        run_d         = run_q;
        rst_n_d       = rst_n_q;

        unique case (state_q)
            ST_IDLE: begin
                if (init_q) begin
                    init_d        = 1'b0;
                    last_toggle_d = s_toggle;
                    f2h_d[31]     = s_toggle;
                end else if (s_toggle != last_toggle_q) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (s_stable) begin
                    if (s_toggle != last_toggle_q) begin
                        cmd_d   = '{toggle: s_toggle, opcode: s_opcode, payload: s_payload};
                        state_d = ST_EXEC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_EXEC: begin
                err_d   = 1'b0;
                resp_d  = '0;
                state_d = ST_ACK;
                case (cmd_q.opcode)
                    OP_NOP, OP_WRITE_INST, OP_WRITE_DATA, OP_CTRL: ;
                    OP_SET_ADDR: addr_d = cmd_q.payload[ADDRESS_WIDTH-1:0];
                    OP_SET_CORE: begin
                        if (32'(cmd_q.payload[2:0]) >= CORE_COUNT) begin
                            err_d = 1'b1;
                        end else begin
                            core_idx_d = cmd_q.payload[2:0];
                            bcast_d    = cmd_q.payload[8];
                        end
                    end
                    OP_WDATA_LO: wdata_d[15:0]  = cmd_q.payload;
                    OP_WDATA_HI: wdata_d[31:16] = cmd_q.payload;
                    OP_READ: begin
                        if (!read_ok) begin
                            err_d = 1'b1;
                        end else begin
                            read_space_d = cmd_q.payload[2:0];
                            wait_d       = 3'(READ_LATENCY - 1);
                            state_d      = ST_WAIT;
                        end
                    end
                    OP_RDATA_HI: resp_d = rdata_hi_q;
                    OP_STATUS:   resp_d = {halted8, exc8};
                    OP_EXC_LO:   resp_d = exc_word[15:0];
                    OP_EXC_HI:   resp_d = {8'h00, exc_word[23:16]};
                    default:     err_d  = 1'b1;
                endcase
            end
            ST_WAIT: begin
                if (wait_q == '0) begin
                    resp_d     = sel_word[15:0];
                    rdata_hi_d = sel_word[31:16];
                    state_d    = ST_ACK;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            ST_ACK: begin
                last_toggle_d = cmd_q.toggle;
                f2h_d         = {cmd_q.toggle, err_q, 14'b0, resp_q};
                if (cmd_q.opcode == OP_CTRL) begin
                    run_d   = cmd_q.payload[CORE_COUNT-1:0];
                    rst_n_d = ~cmd_q.payload[8 +: CORE_COUNT];
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            init_q        <= 1'b1;
            last_toggle_q <= 1'b0;
            cmd_q         <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            core_idx_q    <= '0;
            bcast_q       <= 1'b0;
            read_space_q  <= '0;
            wait_q        <= '0;
            err_q         <= 1'b0;
            resp_q        <= '0;
            rdata_hi_q    <= '0;
            f2h_q         <= '0;
            run_q         <= '0;
            rst_n_q       <= '0;
        end else begin
            state_q       <= state_d;
            init_q        <= init_d;
            last_toggle_q <= last_toggle_d;
            cmd_q         <= cmd_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            core_idx_q    <= core_idx_d;
            bcast_q       <= bcast_d;
            read_space_q  <= read_space_d;
            wait_q        <= wait_d;
            err_q         <= err_d;
            resp_q        <= resp_d;
            rdata_hi_q    <= rdata_hi_d;
            f2h_q         <= f2h_d;
            run_q         <= run_d;
            rst_n_q       <= rst_n_d;
        end
    end

    assign f2h_value    = f2h_q;
    assign core_run     = run_q;
    assign core_reset_n = rst_n_q;
    assign rw_address   = addr_q;
    assign write_data   = wdata_q;

endmodule

// File: tb/tb_gpu_host_bridge.sv
// Directed and random command sequences against a command-level model of the
// host bridge (register file of address/data/core plus per-opcode results).
module tb_gpu_host_bridge;
    localparam int unsigned CC = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [31:0]       h2f_value;
    logic [31:0]       f2h_value;
    logic [CC-1:0]     core_reset_n, core_run, core_halted, core_exception, core_select;
    logic [CC*24-1:0]  core_exception_data;
    logic              enable_write_inst_ram, enable_write_data_ram, enable_read;
    logic [2:0]        read_space;
    logic [15:0]       rw_address;
    logic [31:0]       write_data;
    logic [CC*32-1:0]  read_data;

    gpu_host_bridge #(
        .WORD_WIDTH    (32),
        .ADDRESS_WIDTH (16),
        .CORE_COUNT    (CC),
        .READ_LATENCY  (2)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .h2f_value             (h2f_value),
        .f2h_value             (f2h_value),
        .core_reset_n          (core_reset_n),
        .core_run              (core_run),
        .core_halted           (core_halted),
        .core_exception        (core_exception),
        .core_exception_data   (core_exception_data),
        .core_select           (core_select),
        .enable_write_inst_ram (enable_write_inst_ram),
        .enable_write_data_ram (enable_write_data_ram),
        .read_space            (read_space),
        .enable_read           (enable_read),
        .rw_address            (rw_address),
        .write_data            (write_data),
        .read_data             (read_data)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Pulse observer: counts active cycles of each strobe and records context.
    int          n_inst = 0, n_data = 0, n_rd = 0;
    logic [3:0]  pi_sel, pd_sel, rd_sel;
    logic [31:0] pi_wd, pd_wd;
    logic [15:0] pi_addr, pd_addr;
    logic [2:0]  rd_space;

    always @(negedge clock) begin
        if (enable_write_inst_ram) begin
            n_inst++; pi_sel = core_select; pi_wd = write_data; pi_addr = rw_address;
        end
        if (enable_write_data_ram) begin
            n_data++; pd_sel = core_select; pd_wd = write_data; pd_addr = rw_address;
        end
        if (enable_read) begin
            n_rd++; rd_sel = core_select; rd_space = read_space;
        end
    end

    // Model state
    logic        tog;
    logic [15:0] m_addr, m_rhi;
    logic [31:0] m_wd;
    int          m_core;
    logic        m_bcast;
    logic [3:0]  m_run, m_rstn, m_halt, m_exc;
    logic [31:0] rd [CC];
    logic [23:0] exd [CC];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_addr = '0; m_wd = '0; m_core = 0; m_bcast = 1'b0; m_rhi = '0;
        m_run = '0; m_rstn = '0;
    endtask

    task automatic drive_env();
        for (int c = 0; c < CC; c++) begin
            read_data[c*32 +: 32]           = rd[c];
            core_exception_data[c*24 +: 24] = exd[c];
        end
        core_halted    = m_halt;
        core_exception = m_exc;
    endtask

    task automatic randomize_env();
        for (int c = 0; c < CC; c++) begin
            rd[c]  = $urandom;
            exd[c] = 24'($urandom);
        end
        m_halt = 4'($urandom);
        m_exc  = 4'($urandom);
        drive_env();
    endtask

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (f2h_value[31] === tog) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_cmd(input string tag, input logic [3:0] op, input logic [26:0] pl);
        logic [15:0] e_resp;
        logic        e_err;
        int          e_inst, e_data, e_rd;
        logic [3:0]  e_sel;
        int          i0, d0, r0;
        bit          ok;
        e_resp = '0; e_err = 1'b0; e_inst = 0; e_data = 0; e_rd = 0;
        case (op)
            4'd1: m_addr = pl[15:0];
            4'd2: if (pl[2:0] >= CC) e_err = 1'b1;
                  else begin m_core = int'(pl[2:0]); m_bcast = pl[8]; end
            4'd3: m_wd[15:0]  = pl[15:0];
            4'd4: m_wd[31:16] = pl[15:0];
            4'd5: e_inst = 1;
            4'd6: e_data = 1;
            4'd7: if (pl[2:0] > 3'd4) e_err = 1'b1;
                  else begin e_rd = 1; e_resp = rd[m_core][15:0]; m_rhi = rd[m_core][31:16]; end
            4'd8: e_resp = m_rhi;
            4'd9: begin m_run = pl[3:0]; m_rstn = ~pl[11:8]; end
            4'd10: e_resp = {4'b0, m_halt, 4'b0, m_exc};
            4'd11: e_resp = exd[m_core][15:0];
            4'd12: e_resp = {8'h00, exd[m_core][23:16]};
            4'd13, 4'd14, 4'd15: e_err = 1'b1;
            default: ;
        endcase
        e_sel = m_bcast ? 4'hF : 4'(1 << m_core);
        i0 = n_inst; d0 = n_data; r0 = n_rd;
        tog = ~tog;
        @(posedge clock); #1 h2f_value = {tog, op, pl};
        wait_ack(ok);
        check({tag, " ack"}, 32'(ok), 32'd1);
        check({tag, " resp"}, 32'(f2h_value[15:0]), 32'(e_resp));
        check({tag, " err"}, 32'(f2h_value[30]), 32'(e_err));
        check({tag, " zero"}, 32'(f2h_value[29:16]), 32'd0);
        check({tag, " inst_pulses"}, n_inst - i0, e_inst);
        check({tag, " data_pulses"}, n_data - d0, e_data);
        check({tag, " reads"}, n_rd - r0, e_rd);
        if (e_inst > 0) begin
            check({tag, " inst_sel"}, 32'(pi_sel), 32'(e_sel));
            check({tag, " inst_wd"}, pi_wd, m_wd);
            check({tag, " inst_addr"}, 32'(pi_addr), 32'(m_addr));
        end
        if (e_data > 0) begin
            check({tag, " data_sel"}, 32'(pd_sel), 32'(e_sel));
            check({tag, " data_wd"}, pd_wd, m_wd);
            check({tag, " data_addr"}, 32'(pd_addr), 32'(m_addr));
        end
        if (e_rd > 0) begin
            check({tag, " rd_sel"}, 32'(rd_sel), 32'(1 << m_core));
            check({tag, " rd_space"}, 32'(rd_space), 32'(pl[2:0]));
        end
        check({tag, " run"}, 32'(core_run), 32'(m_run));
        check({tag, " rstn"}, 32'(core_reset_n), 32'(m_rstn));
        check({tag, " idle_sel"}, 32'(core_select), 32'(1 << m_core));
        repeat (2) @(negedge clock);
    endtask

    initial begin
        bit          ok;
        int          r0, i0, d0;
        logic [3:0]  op;
        logic [26:0] pl;

        tog = 1'b1;
        h2f_value = {1'b1, 4'd0, 27'd0};
        for (int c = 0; c < CC; c++) begin rd[c] = '0; exd[c] = '0; end
        m_halt = '0; m_exc = '0;
        drive_env();
        model_reset();

        repeat (4) @(negedge clock);
        check("rst f2h", f2h_value, 32'd0);
        check("rst rstn", 32'(core_reset_n), 32'd0);
        check("rst run", 32'(core_run), 32'd0);
        check("rst enables", {29'd0, enable_write_inst_ram, enable_write_data_ram, enable_read}, 32'd0);
        check("rst sel", 32'(core_select), 32'd1);
        check("rst addr", 32'(rw_address), 32'd0);
        check("rst wd", write_data, 32'd0);

        // Toggle already high across reset release: adopt it, run nothing.
        @(posedge clock); #1 reset = 1'b0;
        repeat (10) @(negedge clock);
        check("boot f2h", f2h_value, 32'h8000_0000);
        check("boot pulses", n_inst + n_data + n_rd, 0);

        do_cmd("ctrl_on", 4'd9, 27'h0000F);

        // Write path on core 2
        do_cmd("set_addr", 4'd1, 27'h0040);
        do_cmd("wdata_lo", 4'd3, 27'hBEEF);
        do_cmd("wdata_hi", 4'd4, 27'hDEAD);
        do_cmd("set_core2", 4'd2, 27'd2);
        do_cmd("write_data", 4'd6, 27'd0);
        check("wd_dir sel", 32'(pd_sel), 32'b0100);
        check("wd_dir word", pd_wd, 32'hDEADBEEF);

        // Read path on core 1
        rd[1] = 32'h12345678;
        drive_env();
        do_cmd("set_core1", 4'd2, 27'd1);
        do_cmd("read_reg", 4'd7, 27'd2);
        check("rd_dir lo", 32'(f2h_value[15:0]), 32'h5678);
        do_cmd("rdata_hi", 4'd8, 27'd0);
        check("rd_dir hi", 32'(f2h_value[15:0]), 32'h1234);

        // Broadcast instruction write
        do_cmd("set_bcast", 4'd2, 27'h100);
        do_cmd("write_inst", 4'd5, 27'd0);
        check("bc pulse sel", 32'(pi_sel), 32'hF);
        check("bc after sel", 32'(core_select), 32'b0001);

        // Illegal core index and error clearing
        do_cmd("set_core5", 4'd2, 27'd5);
        check("core5 err", 32'(f2h_value[30]), 32'd1);
        do_cmd("nop", 4'd0, 27'd0);
        check("nop err", 32'(f2h_value[30]), 32'd0);
        do_cmd("bad_space", 4'd7, 27'd5);
        do_cmd("op13", 4'd13, 27'd0);
        do_cmd("op15", 4'd15, 27'h7FFFFFF);

        // Bouncing command word: only the settled word executes.
        i0 = n_inst; d0 = n_data;
        tog = ~tog;
        @(posedge clock); #1 h2f_value = {tog, 4'd5, 27'd0};
        @(posedge clock); #1 h2f_value = {tog, 4'd6, 27'd1};
        @(posedge clock); #1 h2f_value = {tog, 4'd5, 27'd2};
        @(posedge clock); #1 h2f_value = {tog, 4'd6, 27'd0};
        wait_ack(ok);
        check("bounce ack", 32'(ok), 32'd1);
        check("bounce inst", n_inst - i0, 0);
        check("bounce data", n_data - d0, 1);
        repeat (2) @(negedge clock);

        // Reset while waiting for read data
        do_cmd("set_core3", 4'd2, 27'd3);
        rd[3] = 32'hCAFE_F00D;
        drive_env();
        r0 = n_rd;
        tog = ~tog;
        @(posedge clock); #1 h2f_value = {tog, 4'd7, 27'd1};
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (n_rd != r0) begin ok = 1'b1; break; end
        end
        check("wrst issued", 32'(ok), 32'd1);
        @(posedge clock); #1 reset = 1'b1;
        @(negedge clock);
        check("wrst f2h", f2h_value, 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        model_reset();
        repeat (12) @(negedge clock);
        check("wrst noack", f2h_value, {tog, 31'd0});
        check("wrst noreread", n_rd - r0, 1);
        do_cmd("wrst rhi", 4'd8, 27'd0);
        do_cmd("ctrl_rand", 4'd9, 27'h0A05);

        // Random commands
        for (int n = 0; n < 80; n++) begin
            @(posedge clock); #1 randomize_env();
            op = 4'($urandom_range(0, 15));
            pl = 27'($urandom);
            do_cmd("rnd", op, pl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpu_host_bridge.md
GPU_HOST_BRIDGE -- requirements
Module: gpu_host_bridge

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32, GPU word width (fixed 32 in this revision).
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 16, GPU RAM/register address width (at most 16).
REQ-003 SHALL have parameter CORE_COUNT, default 4, number of attached GPU cores (1..8).
REQ-004 SHALL have parameter READ_LATENCY, default 2, cycles from read enable to valid read_data (1..7).
REQ-005 SHALL have one clock and an asynchronous, active-high reset.
REQ-006 SHALL have port `clock`, input, 1 bit: the single clock.
REQ-007 SHALL have port `reset`, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port `h2f_value`, input, 32 bits: HPS command word; [31] request toggle, [30:27] opcode, [26:0] payload.
REQ-009 SHALL have port `f2h_value`, output, 32 bits: [31] ack toggle, [30] error, [29:16] zero, [15:0] response.
REQ-010 SHALL have port `core_reset_n`, output, CORE_COUNT bits: per-core active-low reset.
REQ-011 SHALL have port `core_run`, output, CORE_COUNT bits: per-core run.
REQ-012 SHALL have port `core_halted`, input, CORE_COUNT bits: per-core halted.
REQ-013 SHALL have port `core_exception`, input, CORE_COUNT bits: per-core exception flag.
REQ-014 SHALL have port `core_exception_data`, input, CORE_COUNT*24 bits: flattened per-core exception data.
REQ-015 SHALL have port `core_select`, output, CORE_COUNT bits: one-hot target core (all ones while broadcasting a write).
REQ-016 SHALL have port `enable_write_inst_ram`, output, 1 bit: one-cycle instruction-RAM write pulse.
REQ-017 SHALL have port `enable_write_data_ram`, output, 1 bit: one-cycle data-RAM write pulse.
REQ-018 SHALL have port `read_space`, output, 3 bits: 0 inst, 1 data, 2 register, 3 floatreg, 4 special.
REQ-019 SHALL have port `enable_read`, output, 1 bit: one-cycle read request pulse.
REQ-020 SHALL have port `rw_address`, output, ADDRESS_WIDTH bits: shared address.
REQ-021 SHALL have port `write_data`, output, WORD_WIDTH bits: shared write data.
REQ-022 SHALL have port `read_data`, input, CORE_COUNT*WORD_WIDTH bits: per-core read results.

Function
REQ-023 SHALL pass h2f_value through a two-flop synchroniser and accept a command only when the synchronised toggle differs from last_toggle AND the word is identical on two consecutive cycles.
REQ-024 SHALL implement states IDLE, SETTLE, EXEC, WAIT, ACK; IDLE->SETTLE on toggle change; SETTLE->EXEC when stable (else stay); EXEC->WAIT for reads, else ->ACK; WAIT->ACK after READ_LATENCY cycles; ACK->IDLE.
REQ-025 SHALL, in ACK, update last_toggle and f2h[31] to the accepted toggle and f2h[30]/[15:0] together in the same cycle.
REQ-026 SHALL define opcodes: 0 NOP; 1 SET_ADDR (payload[ADDRESS_WIDTH-1:0]); 2 SET_CORE (payload[2:0] index, payload[8] write-broadcast); 3 WDATA_LO; 4 WDATA_HI (16-bit halves of write_data); 5 WRITE_INST; 6 WRITE_DATA; 7 READ (payload[2:0] space); 8 RDATA_HI; 9 CTRL (payload[7:0] run mask, payload[15:8] reset mask, 1=hold in reset); 10 STATUS; 11 EXC_LO; 12 EXC_HI.
REQ-027 SHALL return response 0 for non-read commands, except: READ returns result[15:0] and latches result[31:16] for RDATA_HI; STATUS returns {halted[7:0], exception[7:0]} zero-extended; EXC_LO/HI return selected core exception_data[15:0] / {8'b0, [23:16]}.
REQ-028 SHALL set error=1 and perform no side effect for opcodes 13-15, core index >= CORE_COUNT, or read space > 4; error SHALL clear on the next accepted command.
REQ-029 SHALL drive WRITE_INST/WRITE_DATA pulses for exactly one cycle in EXEC; with broadcast set, core_select SHALL be all ones during that pulse only.
REQ-030 SHALL never broadcast reads; READ uses the selected core's read_data slice.
REQ-031 SHALL ignore a new toggle change arriving during SETTLE..ACK until IDLE is re-entered.
REQ-032 SHALL apply CTRL masks to core_run/core_reset_n in the ACK cycle, ignoring mask bits >= CORE_COUNT.

Reset
REQ-033 SHALL, on reset, force f2h_value=0, core_reset_n=0, core_run=0, all enables 0, core_select=one-hot core 0, rw_address=0, write_data=0, state IDLE.
REQ-034 SHALL, in the first cycle after reset release, load last_toggle and f2h[31] from the synchronised toggle without executing a command.
REQ-035 SHALL, on reset during WAIT, discard the pending read and produce no ACK.

Structure
REQ-036 SHALL place opcode, read-space and state encodings in shared package gpu_host_pkg.
REQ-037 SHALL instantiate one sub-module, gpu_host_sync, containing the synchroniser and stability check.

Verification
REQ-038 SHALL verify: SET_ADDR 0x0040, WDATA_LO 0xBEEF, WDATA_HI 0xDEAD, WRITE_DATA on core 2 -> one-cycle pulse, core_select=0b0100, write_data=0xDEADBEEF.
REQ-039 SHALL verify: READ space 2, core 1 read_data=0x12345678, READ_LATENCY=2 -> response 0x5678; RDATA_HI -> 0x1234.
REQ-040 SHALL verify: SET_CORE 0 broadcast, WRITE_INST -> core_select=0b1111 for one pulse cycle, then 0b0001.
REQ-041 SHALL verify: SET_CORE index 5 with CORE_COUNT=4 -> error=1, core_select unchanged; next NOP -> error=0.
REQ-042 SHALL verify: toggle=1 held through reset release -> no command executed, f2h[31]=1.
REQ-043 SHALL verify: h2f word changed on two successive cycles -> no EXEC until stable two cycles; reset in WAIT -> no ack.
